// File: rtl/crpa_coef_loader.sv
// rtl/crpa_coef_loader.sv - Loads CRPA null-former weights into FIR shadow registers over intbus, then mirrors them.
// One coefficient is fetched, written and acknowledged at a time; coef_mirr fires only after the final word lands.
module crpa_coef_loader #(
  parameter int NCH         = 4,
  parameter int NT          = 8,
  parameter int C_WIDTH     = 16,
  parameter int ADDR_W      = 16,
  parameter int FIR_BASE    = 0,
  parameter int FIR_STRIDE  = 64,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               error,
  input  logic               coef_valid,
  output logic               coef_ready,
  input  logic [C_WIDTH-1:0] coef_data,
  output logic               bus_wr,
  output logic [ADDR_W-1:0]  bus_addr,
  output logic [31:0]        bus_wdata,
  input  logic               bus_ack,
  output logic               coef_mirr
);

  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TAP_W = (NT > 1) ? $clog2(NT) : 1;
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_GET, S_WRITE, S_MIRROR, S_FINISH, S_ERR} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   ch;
  logic [TAP_W-1:0]  tap;
  logic [TO_W-1:0]   wait_cnt;
  logic              last_word;
  logic              timed_out;

  assign last_word = (ch == CH_W'(NCH - 1)) && (tap == TAP_W'(NT - 1));
  // wait_cnt counts ack-less WRITE cycles already spent, so WRITE lasts at most ACK_TIMEOUT cycles
  assign timed_out = (wait_cnt == TO_W'(ACK_TIMEOUT - 1));

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    coef_ready = 1'b0;
    bus_wr     = 1'b0;
    coef_mirr  = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_GET;
      S_GET: begin
        busy       = 1'b1;
        coef_ready = 1'b1;
        if (coef_valid) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy   = 1'b1;
        bus_wr = 1'b1;
        if (bus_ack) state_nxt = last_word ? S_MIRROR : S_GET;
        else if (timed_out) state_nxt = S_ERR;
      end
      S_MIRROR: begin
        busy      = 1'b1;
        coef_mirr = 1'b1;
        state_nxt = S_FINISH;
      end
      S_FINISH: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ch        <= '0;
      tap       <= '0;
      wait_cnt  <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      error     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            error <= 1'b0;
            ch    <= '0;
            tap   <= '0;
          end
        end
        S_GET: begin
          // address and data are latched at capture so they hold still for the whole write
          if (coef_valid) begin
            bus_addr  <= ADDR_W'(32'(FIR_BASE) + 32'(ch) * 32'(FIR_STRIDE) + 32'(tap));
            bus_wdata <= 32'(signed'(coef_data));
            wait_cnt  <= '0;
          end
        end
        S_WRITE: begin
          if (bus_ack) begin
            if (tap == TAP_W'(NT - 1)) begin
              tap <= '0;
              ch  <= ch + CH_W'(1);
            end else begin
              tap <= tap + TAP_W'(1);
            end
          end else if (timed_out) begin
            error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crpa_coef_loader.sv
// tb/tb_crpa_coef_loader.sv - Randomized bench for crpa_coef_loader against a load-level reference model.
module tb_crpa_coef_loader;
  localparam int NCH = 4, NT = 8, N = NCH * NT, TO = 10, STRIDE = 64;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, coef_valid = 1'b0, bus_ack = 1'b0;
  logic [15:0] coef_data = '0;
  logic busy, done, error, coef_ready, bus_wr, coef_mirr;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;

  always #5 clk = ~clk;

  crpa_coef_loader #(.NCH(NCH), .NT(NT), .C_WIDTH(16), .ADDR_W(16), .FIR_BASE(0),
                     .FIR_STRIDE(STRIDE), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .coef_mirr(coef_mirr));

  int errors = 0, checks = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] sx(input logic [15:0] c);
    return {{16{c[15]}}, c};
  endfunction

  function automatic logic [31:0] exp_addr(input int k);
    return 32'((k / NT) * STRIDE + (k % NT));
  endfunction

  // Stimulus knobs and source stream
  logic [15:0] src_q[$];
  logic [15:0] exp_src[$];
  int gap_pct = 0, ack_delay = 0, withhold = -1, ack_idx = 0, wr_cnt = 0;
  bit ack_tie = 0, ack_rand = 0, ack_noise = 0;
  bit s_hs = 0, s_whs = 0, s_bw = 0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (s_hs && src_q.size() > 0) void'(src_q.pop_front());
    if (s_whs) ack_idx++;
    if (src_q.size() == 0) begin
      coef_valid = 1'b0;
    end else if (coef_valid && !s_hs) begin
      coef_data = src_q[0];
    end else if ($urandom_range(99) >= gap_pct) begin
      coef_valid = 1'b1;
      coef_data  = src_q[0];
    end else begin
      coef_valid = 1'b0;
      coef_data  = 16'($urandom);
    end
    if (bus_wr) begin
      wr_cnt = (s_bw && !s_whs) ? wr_cnt + 1 : 0;
      if (ack_rand && wr_cnt == 0) ack_delay = $urandom_range(3);
    end else begin
      wr_cnt = 0;
    end
    if (ack_tie) bus_ack = 1'b1;
    else if (bus_wr) bus_ack = (wr_cnt >= ack_delay) && (ack_idx != withhold);
    else bus_ack = ack_noise ? 1'($urandom_range(1)) : 1'b0;
  end

  // Reference model: a load is one accepted start, N fetch/write pairs, a mirror, then done
  typedef enum {M_IDLE, M_LOAD, M_MIRR, M_FIN, M_ERR} mph_t;
  mph_t mph = M_IDLE;
  bit chk_en = 0, m_error = 0, prev_whs = 0;
  logic [15:0] mq[$];
  int m_wr = 0, m_wait = 0, bw_cyc = 0, start_cyc = 0;
  int mirr_cnt = 0, done_cnt = 0, err_cnt = 0, mirr_off = 0, done_off = 0;
  logic [31:0] wlog_addr[N];
  logic [31:0] wlog_data[N];
  int wlog_cyc[N];

  always @(negedge clk) begin
    s_hs  = coef_valid && coef_ready;
    s_whs = bus_wr && bus_ack;
    s_bw  = bus_wr;
    if (coef_mirr === 1'b1) mirr_cnt++;
    if (chk_en) begin
      case (mph)
        M_IDLE: begin
          chk("idle_ctl", 32'({busy, done, coef_ready, bus_wr, coef_mirr}), 32'(0));
          chk("idle_error", 32'(error), 32'(m_error));
          if (start) begin
            mph = M_LOAD; m_error = 0; mq.delete();
            m_wr = 0; m_wait = 0; bw_cyc = 0; start_cyc = cyc;
          end
        end
        M_LOAD: begin
          chk("load_ctl", 32'({busy, done, coef_mirr, error}), 32'(4'b1000));
          chk("ready_xor_wr", 32'(coef_ready ^ bus_wr), 32'(1));
          if (coef_ready && coef_valid) begin
            chk("fetch_once", 32'(mq.size()), 32'(m_wr));
            mq.push_back(coef_data);
          end
          if (bus_wr) begin
            bw_cyc++;
            chk("bus_gap", 32'(prev_whs), 32'(0));
            chk("wr_pending", 32'(mq.size()), 32'(m_wr + 1));
            chk("addr", 32'(bus_addr), exp_addr(m_wr));
            if (mq.size() > m_wr) chk("wdata", bus_wdata, sx(mq[m_wr]));
            if (bus_ack) begin
              if (m_wr < N) begin
                wlog_addr[m_wr] = 32'(bus_addr);
                wlog_data[m_wr] = bus_wdata;
                wlog_cyc[m_wr]  = cyc - start_cyc;
              end
              m_wr++; m_wait = 0;
              if (m_wr == N) mph = M_MIRR;
            end else begin
              m_wait++;
              if (m_wait == TO) begin mph = M_ERR; m_error = 1; end
            end
          end
        end
        M_MIRR: begin
          chk("mirror_ctl", 32'({coef_mirr, busy, bus_wr, coef_ready, done}), 32'(5'b11000));
          mirr_off = cyc - start_cyc;
          mph = M_FIN;
        end
        M_FIN: begin
          chk("finish_ctl", 32'({done, busy, coef_mirr, bus_wr, coef_ready}), 32'(5'b10000));
          done_cnt++; done_off = cyc - start_cyc;
          mph = M_IDLE;
        end
        M_ERR: begin
          chk("err_ctl", 32'({error, busy, done, coef_mirr, bus_wr, coef_ready}), 32'(6'b100000));
          err_cnt++;
          mph = M_IDLE;
        end
        default: mph = M_IDLE;
      endcase
      if (rst) begin mph = M_IDLE; m_error = 0; end
    end
    prev_whs = s_whs;
  end

  task automatic fill(input int kind);
    src_q.delete();
    for (int i = 0; i < N; i++) begin
      if (kind == 0) src_q.push_back(16'(i));
      else if (kind == 1 && i == 0) src_q.push_back(16'h8000);
      else if (kind == 1 && i == 1) src_q.push_back(16'h7FFF);
      else src_q.push_back(16'($urandom));
    end
    exp_src = src_q;
  endtask

  task automatic pulse_start();
    @(posedge clk); #2;
    ack_idx = 0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int d, e, n;
    d = done_cnt; e = err_cnt; n = 0;
    while (done_cnt == d && err_cnt == e && n < budget) begin
      @(posedge clk); #2; n++;
    end
    chk("load_end", 32'(done_cnt + err_cnt), 32'(d + e + 1));
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic chk_order();
    for (int i = 0; i < N; i++) chk("order", wlog_data[i], sx(exp_src[i]));
  endtask

  int m0, d0, e0, n;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", 32'({busy, done, error, coef_ready, bus_wr, coef_mirr}), 32'(0));
    chk("reset_addr", 32'(bus_addr), 32'(0));
    chk("reset_wdata", bus_wdata, 32'(0));
    @(posedge clk); #2;
    rst = 1'b0; chk_en = 1;

    // Continuous valid, ack tied high: exact latency and address map
    ack_tie = 1; fill(0); m0 = mirr_cnt;
    pulse_start(); wait_end(400);
    chk("t1_mirrors", 32'(mirr_cnt - m0), 32'(1));
    chk("t1_writes", 32'(m_wr), 32'(N));
    chk("t1_mirr_cycle", 32'(mirr_off), 32'(65));
    chk("t1_done_cycle", 32'(done_off), 32'(66));
    chk("t1_first_wr", 32'(wlog_cyc[0]), 32'(2));
    chk("t1_last_wr", 32'(wlog_cyc[N-1]), 32'(64));
    chk("t1_addr_ch1", wlog_addr[8], 32'd64);
    chk("t1_addr_last", wlog_addr[N-1], 32'd199);
    chk_order();

    // Sign extension extremes
    fill(1);
    pulse_start(); wait_end(400);
    chk("t2_neg", wlog_data[0], 32'hFFFF8000);
    chk("t2_pos", wlog_data[1], 32'h00007FFF);

    // Ack delayed three cycles on every write
    ack_tie = 0; ack_delay = 3; fill(2); m0 = mirr_cnt;
    pulse_start(); wait_end(1000);
    chk("t3_bus_wr_cycles", 32'(bw_cyc), 32'(4 * N));
    chk("t3_writes", 32'(m_wr), 32'(N));
    chk("t3_mirrors", 32'(mirr_cnt - m0), 32'(1));
    chk_order();

    // Ack withheld on word 5: timeout, no mirror, error sticky until next start
    ack_delay = 0; withhold = 5; fill(2);
    m0 = mirr_cnt; d0 = done_cnt; e0 = err_cnt;
    pulse_start(); wait_end(400);
    chk("t4_errors", 32'(err_cnt - e0), 32'(1));
    chk("t4_no_mirror", 32'(mirr_cnt - m0), 32'(0));
    chk("t4_no_done", 32'(done_cnt - d0), 32'(0));
    chk("t4_writes", 32'(m_wr), 32'(5));
    chk("t4_bus_wr_cycles", 32'(bw_cyc), 32'(5 + TO));
    repeat (3) @(posedge clk); #2;
    chk("t4_err_sticky", 32'(error), 32'(1));
    withhold = -1; fill(2); m0 = mirr_cnt;
    pulse_start(); wait_end(400);
    chk("t4_reload_mirror", 32'(mirr_cnt - m0), 32'(1));
    chk("t4_err_cleared", 32'(error), 32'(0));
    chk_order();

    // Reset after word 12 is written, then a clean reload
    ack_delay = 1; fill(2); m0 = mirr_cnt;
    pulse_start();
    n = 0;
    while (ack_idx < 12 && n < 500) begin @(posedge clk); #2; n++; end
    chk("t5_reach_word12", 32'(ack_idx), 32'(12));
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_ctl", 32'({busy, done, error, coef_ready, bus_wr, coef_mirr}), 32'(0));
    chk("t5_rst_addr", 32'(bus_addr), 32'(0));
    chk("t5_rst_wdata", bus_wdata, 32'(0));
    chk("t5_no_mirror", 32'(mirr_cnt - m0), 32'(0));
    fill(2);
    pulse_start(); wait_end(600);
    chk("t5_reload_mirror", 32'(mirr_cnt - m0), 32'(1));
    chk("t5_first_addr", wlog_addr[0], 32'(0));
    chk_order();

    // Random valid gaps, random ack latency, stray acks and starts while busy
    gap_pct = 40; ack_rand = 1; ack_noise = 1; fill(2);
    m0 = mirr_cnt; d0 = done_cnt;
    pulse_start();
    n = 0;
    while (m_wr < 20 && n < 1000) begin
      @(posedge clk); #2;
      start = 1'($urandom_range(3) == 0);
      n++;
    end
    start = 1'b0;
    wait_end(1000);
    chk("t6_mirrors", 32'(mirr_cnt - m0), 32'(1));
    chk("t6_dones", 32'(done_cnt - d0), 32'(1));
    chk("t6_writes", 32'(m_wr), 32'(N));
    chk_order();

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
